// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store access unit in front of a 2**AW x 32 data RAM that has a
//   combinational read and a level-sensitive write. The unit takes one request
//   at a time over a valid/ready handshake. It turns byte, halfword and word
//   accesses into RAM word reads and writes. Sub-word stores are done as a
//   read-modify-write. Each request gets exactly one response pulse.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_signed        sign-extend sub-word loads
//   req_addr          byte address (AW+2 bits)
//   req_wdata         right-justified store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        load result (0 for stores and errors), held until next response
//   resp_err          misaligned or illegal size, held until next response
//   ram_addr          RAM word address
//   ram_rw            1 = read, 0 = write
//   ram_data_in       RAM write data
//   ram_data_out      RAM read data
module mem_access_unit #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [AW+1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            resp_valid,
    output logic [DW-1:0]   resp_rdata,
    output logic            resp_err,
    output logic [AW-1:0]   ram_addr,
    output logic            ram_rw,
    output logic [DW-1:0]   ram_data_in,
    input  logic [DW-1:0]   ram_data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_ERR, S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      size_q, size_d;
    logic            signed_q, signed_d;
    logic [1:0]      lane_q, lane_d;
    logic [15:0]     wdata_q, wdata_d;     // only sub-word stores need latched data
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_data_in_q, ram_data_in_d;
    logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic            req_bad;
    logic [DW-1:0]   shifted;
    logic [DW-1:0]   load_val;
    logic [DW-1:0]   merged;

    // Illegal size or a sub-word/word access that straddles its natural alignment.
    assign req_bad = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    // Bring the addressed lane down to bit 0; halves are aligned so lane_q[0]=0.
    assign shifted = ram_data_out >> {lane_q, 3'b000};

    always_comb begin
        load_val = ram_data_out;
        case (size_q)
            2'b00: load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01: load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_val = ram_data_out;
        endcase
    end

    // Replace only the addressed lane(s) of the word just read.
    always_comb begin
        merged = ram_data_out;
        for (int k = 0; k < 4; k++) begin
            if (size_q == 2'b00 && lane_q == 2'(k))
                merged[8*k +: 8] = wdata_q[7:0];
        end
        if (size_q == 2'b01) begin
            if (lane_q[1]) merged[31:16] = wdata_q;
            else           merged[15:0]  = wdata_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        signed_d      = signed_q;
        lane_d        = lane_q;
        wdata_d       = wdata_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    lane_d   = req_addr[1:0];
                    wdata_d  = req_wdata[15:0];
                    if (req_bad) begin
                        // RAM-facing registers stay put: errors never touch the RAM.
                        state_d = S_ERR;
                    end else begin
                        ram_addr_d = req_addr[AW+1:2];
                        if (!req_we) begin
                            state_d = S_LOAD;
                        end else if (req_size == 2'b10) begin
                            ram_data_in_d = req_wdata;
                            state_d       = S_WRITE;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end
                end
            end
            S_LOAD: begin
                resp_rdata_d = load_val;
                resp_err_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_RMW_RD: begin
                ram_data_in_d = merged;
                state_d       = S_WRITE;
            end
            S_WRITE: begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_ERR: begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            lane_q        <= 2'b00;
            wdata_q       <= '0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            lane_q        <= lane_d;
            wdata_q       <= wdata_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_RESP);
    assign ram_rw      = (state_q != S_WRITE);
    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized requests,
// checked against a word-array reference model of the RAM contents.
module tb_mem_access_unit;
    localparam int AW = 4;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_rw;
    logic [31:0]   ram_data_in;
    logic [31:0]   ram_data_out;

    logic [31:0]   tb_ram  [NW];   // the RAM the DUT talks to
    logic [31:0]   ref_mem [NW];   // expected contents

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.AW(AW), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_rw(ram_rw),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    assign ram_data_out = tb_ram[ram_addr];
    always @(posedge clk) if (!ram_rw) tb_ram[ram_addr] <= ram_data_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: the architectural effect of one request, from the access rules.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [AW+1:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rd, output logic err,
                              output int lat, output int wr);
        int w, sh;
        logic [31:0] mask, v;
        w  = int'(addr) / 4;
        sh = (int'(addr) % 4) * 8;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        rd = 0; lat = 2; wr = 0;
        if (err) return;
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!we) begin
            v = (ref_mem[w] >> sh) & mask;
            if (sgn && size == 2'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
            if (sgn && size == 2'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            rd = v;
        end else begin
            wr = 1;
            if (size != 2'd2) lat = 3;
            ref_mem[w] = (ref_mem[w] & ~(mask << sh)) | ((wdata & mask) << sh);
        end
    endtask

    // Issue one request from idle and check latency, write activity and response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [AW+1:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rd; logic exp_err; int exp_lat, exp_wr;
        int lat, wcnt, wcyc;
        ref_access(we, size, sgn, addr, wdata, exp_rd, exp_err, exp_lat, exp_wr);
        @(negedge clk);
        check_eq("ready_idle", 32'(req_ready), 32'd1);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        lat = 0; wcnt = 0; wcyc = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                check_eq("ready_busy", 32'(req_ready), 32'd0);
            end
            if (!ram_rw) begin wcnt++; wcyc = k; end
            if (resp_valid) lat = k;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("write_cycles", wcnt, exp_wr);
        if (exp_wr == 1) check_eq("write_slot", wcyc, exp_lat - 1);
        check_eq("rdata", resp_rdata, exp_rd);
        check_eq("err", 32'(resp_err), 32'(exp_err));
        $display("txn we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d (exp %h/%0d)",
                 we, size, sgn, addr, wdata, lat, resp_rdata, resp_err, exp_rd, exp_err);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            tb_ram[i] = $urandom;
        end
        tb_ram[0] = 32'h1; tb_ram[1] = 32'hF; tb_ram[9] = 32'hE;
        for (int i = 0; i < NW; i++) ref_mem[i] = tb_ram[i];

        // Reset state
        #12;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_rw", 32'(ram_rw), 32'd1);
        check_eq("rst_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_wdata", ram_data_in, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", 32'(resp_err), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed scenarios
        do_req(1'b0, 2'd2, 1'b0, 6'h04, 32'h0);          // word load -> 0000000F
        do_req(1'b1, 2'd0, 1'b0, 6'h05, 32'h80);         // store byte
        do_req(1'b0, 2'd0, 1'b1, 6'h05, 32'h0);          // -> FFFFFF80
        do_req(1'b0, 2'd0, 1'b0, 6'h05, 32'h0);          // -> 00000080
        do_req(1'b0, 2'd2, 1'b0, 6'h04, 32'h0);          // -> 0000800F
        do_req(1'b1, 2'd1, 1'b0, 6'h26, 32'hBEEF);       // word 9 -> BEEF000E
        check_eq("word9", tb_ram[9], 32'hBEEF000E);
        do_req(1'b0, 2'd1, 1'b1, 6'h26, 32'h0);          // -> FFFFBEEF
        do_req(1'b1, 2'd1, 1'b0, 6'h03, 32'h1234);       // misaligned half store
        check_eq("word0", tb_ram[0], 32'h1);
        do_req(1'b0, 2'd3, 1'b0, 6'h08, 32'h0);          // illegal size
        do_req(1'b0, 2'd0, 1'b1, 6'h3F, 32'h0);          // top byte address
        do_req(1'b0, 2'd2, 1'b0, 6'h06, 32'h0);          // misaligned word load

        // Back-to-back loads with req_valid held high
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 6'h04;
        req_valid = 1'b1;
        @(posedge clk);
        for (int s = 0; s <= 8; s++) begin
            @(negedge clk);
            if (s == 6) req_valid = 1'b0;
            check_eq($sformatf("b2b_valid%0d", s), 32'(resp_valid), 32'((s % 3) == 1));
            check_eq($sformatf("b2b_ready%0d", s), 32'(req_ready), 32'((s % 3) == 2));
            if (resp_valid) check_eq("b2b_rdata", resp_rdata, ref_mem[1]);
        end
        $display("txn back-to-back x3 word loads at 04 done");

        // Reset while in the read phase of a read-modify-write
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd0; req_addr = 6'h09; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("rmw_rd_rw", 32'(ram_rw), 32'd1);
        check_eq("rmw_rd_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("abort_rw", 32'(ram_rw), 32'd1);
        check_eq("abort_ready", 32'(req_ready), 32'd1);
        check_eq("abort_valid", 32'(resp_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (resp_valid || !ram_rw) seen++;
            end
            check_eq("abort_quiet", seen, 0);
        end
        $display("txn reset during RMW read of byte 09 aborted");
        do_req(1'b0, 2'd2, 1'b0, 6'h08, 32'h0);          // unmodified word 2

        // Randomized requests
        for (int t = 0; t < 40; t++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   6'($urandom), $urandom);
        end

        for (int i = 0; i < NW; i++) check_eq($sformatf("ram%0d", i), tb_ram[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
